// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: one-hot T1..T6 ring counter plus opcode decode
// into the per-T-state control word; freezes on HLT until reset.
module sap1_control_sequencer #(
    parameter logic [3:0] OP_LDA       = 4'b0000,
    parameter logic [3:0] OP_ADD       = 4'b0001,
    parameter logic [3:0] OP_SUB       = 4'b0010,
    parameter logic [3:0] OP_OUT       = 4'b1110,
    parameter logic [3:0] OP_HLT       = 4'b1111,
    parameter bit         EARLY_RETURN = 1'b0
) (
    input  logic       clk,
    input  logic       async_reset,
    input  logic [3:0] opcode,
    output logic       pc_inc,
    output logic       pc_o_en,
    output logic       mar_i_en,
    output logic       ram_o_en,
    output logic       ir_i_en,
    output logic       ir_o_en,
    output logic       acc_i_en,
    output logic       acc_o_en,
    output logic       b_i_en,
    output logic       alu_sub,
    output logic       alu_o_en,
    output logic       out_i_en,
    output logic [5:0] tstate,
    output logic       instr_done,
    output logic       halted
);
    // state | meaning
    // T1    | PC drives bus, MAR loads
    // T2    | PC increments
    // T3    | RAM drives bus, IR loads
    // T4    | operand address to MAR (LDA/ADD/SUB), A to OUT (OUT), HLT latches halt
    // T5    | RAM data to A (LDA) or B (ADD/SUB)
    // T6    | ALU result to A (ADD/SUB)
    // HALT  | halted = 1, tstate frozen at T5, all controls 0
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    logic [5:0] tstate_q, tstate_d;
    logic       halted_q, halted_d;
    logic       is_mem_op, is_short_op, run;

    assign is_mem_op   = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
    assign is_short_op = !is_mem_op && (opcode != OP_HLT);
    // Controls are gated by reset directly so they drop without waiting for an edge.
    assign run         = async_reset && !halted_q;

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            tstate_q <= T1;
            halted_q <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        tstate_d = tstate_q;
        halted_d = halted_q;
        if (!halted_q) begin
            tstate_d = {tstate_q[4:0], tstate_q[5]};
            if (tstate_q == T4) begin
                if (opcode == OP_HLT)
                    halted_d = 1'b1;
                else if (EARLY_RETURN && is_short_op)
                    tstate_d = T1;
            end
        end
    end

    always_comb begin
        pc_inc     = 1'b0;
        pc_o_en    = 1'b0;
        mar_i_en   = 1'b0;
        ram_o_en   = 1'b0;
        ir_i_en    = 1'b0;
        ir_o_en    = 1'b0;
        acc_i_en   = 1'b0;
        acc_o_en   = 1'b0;
        b_i_en     = 1'b0;
        alu_sub    = 1'b0;
        alu_o_en   = 1'b0;
        out_i_en   = 1'b0;
        instr_done = 1'b0;
        if (run) begin
            case (tstate_q)
                T1: begin
                    pc_o_en  = 1'b1;
                    mar_i_en = 1'b1;
                end
                T2: pc_inc = 1'b1;
                T3: begin
                    ram_o_en = 1'b1;
                    ir_i_en  = 1'b1;
                end
                T4: begin
                    if (is_mem_op) begin
                        ir_o_en  = 1'b1;
                        mar_i_en = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        acc_o_en = 1'b1;
                        out_i_en = 1'b1;
                    end
                    instr_done = EARLY_RETURN && is_short_op;
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ram_o_en = 1'b1;
                        acc_i_en = 1'b1;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ram_o_en = 1'b1;
                        b_i_en   = 1'b1;
                    end
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_o_en = 1'b1;
                        acc_i_en = 1'b1;
                        alu_sub  = (opcode == OP_SUB);
                    end
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign tstate = tstate_q;
    assign halted = halted_q;
endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Bench for sap1_control_sequencer: table vectors, directed corner cases and
// random opcodes against a step-counting reference model, for both EARLY_RETURN settings.
module tb_sap1_control_sequencer;
    localparam int B_CP = 11, B_EP = 10, B_LM = 9, B_CE = 8, B_LI = 7, B_EI = 6;
    localparam int B_LA = 5, B_EA = 4, B_LB = 3, B_SU = 2, B_EU = 1, B_LO = 0;

    logic       clk = 1'b0;
    logic       async_reset = 1'b0;
    logic [3:0] op0 = 4'd0, op1 = 4'd0;
    wire  [11:0] cw0, cw1;
    wire  [5:0]  ts0, ts1;
    wire         done0, done1, halt0, halt1;

    int checks = 0;
    int errors = 0;

    int         m_step [2];
    bit         m_halt [2];
    logic [3:0] cur_op [2];

    typedef struct {
        logic [3:0]  op;
        int          step;
        logic [11:0] cw;
        logic        done;
    } vec_t;
    vec_t tbl [24];

    always #5 clk = ~clk;

    sap1_control_sequencer #(.EARLY_RETURN(1'b0)) dut0 (
        .clk(clk), .async_reset(async_reset), .opcode(op0),
        .pc_inc(cw0[B_CP]), .pc_o_en(cw0[B_EP]), .mar_i_en(cw0[B_LM]), .ram_o_en(cw0[B_CE]),
        .ir_i_en(cw0[B_LI]), .ir_o_en(cw0[B_EI]), .acc_i_en(cw0[B_LA]), .acc_o_en(cw0[B_EA]),
        .b_i_en(cw0[B_LB]), .alu_sub(cw0[B_SU]), .alu_o_en(cw0[B_EU]), .out_i_en(cw0[B_LO]),
        .tstate(ts0), .instr_done(done0), .halted(halt0)
    );

    sap1_control_sequencer #(.EARLY_RETURN(1'b1)) dut1 (
        .clk(clk), .async_reset(async_reset), .opcode(op1),
        .pc_inc(cw1[B_CP]), .pc_o_en(cw1[B_EP]), .mar_i_en(cw1[B_LM]), .ram_o_en(cw1[B_CE]),
        .ir_i_en(cw1[B_LI]), .ir_o_en(cw1[B_EI]), .acc_i_en(cw1[B_LA]), .acc_o_en(cw1[B_EA]),
        .b_i_en(cw1[B_LB]), .alu_sub(cw1[B_SU]), .alu_o_en(cw1[B_EU]), .out_i_en(cw1[B_LO]),
        .tstate(ts1), .instr_done(done1), .halted(halt1)
    );

    a_bus0: assert property (@(negedge clk)
        $onehot0({cw0[B_EP], cw0[B_CE], cw0[B_EI], cw0[B_EA], cw0[B_EU]}))
        else $error("FAIL bus_onehot_assert dut0");
    a_bus1: assert property (@(negedge clk)
        $onehot0({cw1[B_EP], cw1[B_CE], cw1[B_EI], cw1[B_EA], cw1[B_EU]}))
        else $error("FAIL bus_onehot_assert dut1");

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_short(input logic [3:0] op);
        return !(op inside {4'd0, 4'd1, 4'd2, 4'd15});
    endfunction

    // Reference control word from the per-T-state table, step numbered 1..6.
    function automatic logic [11:0] exp_cw(input int step, input logic [3:0] op, input bit hlt);
        logic [11:0] w;
        w = '0;
        if (hlt) return w;
        case (step)
            1: begin w[B_EP] = 1'b1; w[B_LM] = 1'b1; end
            2: w[B_CP] = 1'b1;
            3: begin w[B_CE] = 1'b1; w[B_LI] = 1'b1; end
            4: if (op inside {4'd0, 4'd1, 4'd2}) begin w[B_EI] = 1'b1; w[B_LM] = 1'b1; end
               else if (op == 4'd14) begin w[B_EA] = 1'b1; w[B_LO] = 1'b1; end
            5: if (op == 4'd0) begin w[B_CE] = 1'b1; w[B_LA] = 1'b1; end
               else if (op == 4'd1 || op == 4'd2) begin w[B_CE] = 1'b1; w[B_LB] = 1'b1; end
            6: if (op == 4'd1) begin w[B_EU] = 1'b1; w[B_LA] = 1'b1; end
               else if (op == 4'd2) begin w[B_EU] = 1'b1; w[B_SU] = 1'b1; w[B_LA] = 1'b1; end
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] pick_op();
        int r;
        r = $urandom_range(0, 7);
        if (r < 3) return 4'(r);
        if (r == 3) return 4'd14;
        return 4'($urandom_range(3, 13));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_step[i] = 1;
            m_halt[i] = 1'b0;
            cur_op[i] = pick_op();
        end
    endfunction

    function automatic void advance_model(input int i);
        if (m_halt[i]) return;
        if (m_step[i] == 4 && cur_op[i] == 4'd15) begin
            m_halt[i] = 1'b1;
            m_step[i] = 5;
        end else if (m_step[i] == 4 && i == 1 && is_short(cur_op[i])) begin
            m_step[i] = 1;
        end else begin
            m_step[i] = (m_step[i] % 6) + 1;
        end
        if (m_step[i] == 1) cur_op[i] = pick_op();
    endfunction

    task automatic compare_all(input string tag);
        logic [11:0] cw;
        logic [5:0]  ts;
        logic        dn, hl;
        bit          edone;
        for (int i = 0; i < 2; i++) begin
            cw = (i == 0) ? cw0 : cw1;
            ts = (i == 0) ? ts0 : ts1;
            dn = (i == 0) ? done0 : done1;
            hl = (i == 0) ? halt0 : halt1;
            edone = !m_halt[i] && (m_step[i] == 6 || (i == 1 && m_step[i] == 4 && is_short(cur_op[i])));
            chk($sformatf("%s dut%0d cw", tag, i), 32'(cw), 32'(exp_cw(m_step[i], cur_op[i], m_halt[i])));
            chk($sformatf("%s dut%0d tstate", tag, i), 32'(ts), 32'(6'b1 << (m_step[i] - 1)));
            chk($sformatf("%s dut%0d instr_done", tag, i), 32'(dn), 32'(edone));
            chk($sformatf("%s dut%0d halted", tag, i), 32'(hl), 32'(m_halt[i]));
            chk($sformatf("%s dut%0d bus_onehot0", tag, i),
                32'($onehot0({cw[B_EP], cw[B_CE], cw[B_EI], cw[B_EA], cw[B_EU]})), 32'd1);
            chk($sformatf("%s dut%0d su_without_eu", tag, i), 32'(cw[B_SU] & ~cw[B_EU]), 32'd0);
        end
    endtask

    // Called at a falling edge; opcode is garbage while the IR is not yet valid.
    task automatic drive_and_check();
        op0 = (m_step[0] < 4) ? 4'($urandom_range(0, 15)) : cur_op[0];
        op1 = (m_step[1] < 4) ? 4'($urandom_range(0, 15)) : cur_op[1];
        #1;
        compare_all("run");
        if (m_step[0] < 4 || m_step[1] < 4) begin
            if (m_step[0] < 4) op0 = 4'($urandom_range(0, 15));
            if (m_step[1] < 4) op1 = 4'($urandom_range(0, 15));
            #1;
            compare_all("opcode_ignored");
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int i = 0; i < 2; i++) advance_model(i);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " cw0"}, 32'(cw0), 32'd0);
        chk({tag, " cw1"}, 32'(cw1), 32'd0);
        chk({tag, " done"}, 32'({done0, done1}), 32'd0);
        chk({tag, " halted"}, 32'({halt0, halt1}), 32'd0);
        chk({tag, " tstate0"}, 32'(ts0), 32'h01);
        chk({tag, " tstate1"}, 32'(ts1), 32'h01);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        async_reset = 1'b0;
        #1;
        check_reset_outputs("reset_hold");
        repeat (2) begin
            @(negedge clk);
            check_reset_outputs("reset_hold");
        end
        async_reset = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  t_ops [4];
        logic [11:0] t_w4 [4];
        logic [11:0] t_w5 [4];
        logic [11:0] t_w6 [4];
        int first0, first1;
        logic [5:0] ts_after;

        t_ops = '{4'd0, 4'd1, 4'd2, 4'd14};
        t_w4  = '{12'h240, 12'h240, 12'h240, 12'h011};
        t_w5  = '{12'h120, 12'h108, 12'h108, 12'h000};
        t_w6  = '{12'h000, 12'h022, 12'h026, 12'h000};
        for (int k = 0; k < 4; k++) begin
            tbl[k*6 + 0] = '{t_ops[k], 1, 12'h600, 1'b0};
            tbl[k*6 + 1] = '{t_ops[k], 2, 12'h800, 1'b0};
            tbl[k*6 + 2] = '{t_ops[k], 3, 12'h180, 1'b0};
            tbl[k*6 + 3] = '{t_ops[k], 4, t_w4[k], 1'b0};
            tbl[k*6 + 4] = '{t_ops[k], 5, t_w5[k], 1'b0};
            tbl[k*6 + 5] = '{t_ops[k], 6, t_w6[k], 1'b1};
        end

        // Fetch + LDA/ADD/SUB/OUT on the EARLY_RETURN=0 instance from fixed vectors.
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            if (tbl[i].step == 1) cur_op[0] = tbl[i].op;
            drive_and_check();
            chk($sformatf("tbl[%0d] cw", i), 32'(cw0), 32'(tbl[i].cw));
            chk($sformatf("tbl[%0d] tstate", i), 32'(ts0), 32'(6'b1 << (tbl[i].step - 1)));
            chk($sformatf("tbl[%0d] instr_done", i), 32'(done0), 32'(tbl[i].done));
            advance();
        end

        // OUT instruction length with and without early return.
        apply_reset();
        cur_op[0] = 4'd14;
        cur_op[1] = 4'd14;
        first0 = 0;
        first1 = 0;
        ts_after = '0;
        for (int c = 1; c <= 8; c++) begin
            drive_and_check();
            if (first1 != 0 && c == first1 + 1) ts_after = ts1;
            if (first0 == 0 && done0) first0 = c;
            if (first1 == 0 && done1) first1 = c;
            advance();
        end
        chk("out_cycles_er0", 32'(first0), 32'd6);
        chk("out_cycles_er1", 32'(first1), 32'd4);
        chk("out_er1_next_is_t1", 32'(ts_after), 32'h01);

        // HLT: freeze at T5 with controls off, then an async reset pulse.
        apply_reset();
        cur_op[0] = 4'd15;
        cur_op[1] = 4'd15;
        repeat (4) begin
            drive_and_check();
            advance();
        end
        drive_and_check();
        chk("halt halted0", 32'(halt0), 32'd1);
        chk("halt tstate0", 32'(ts0), 32'h10);
        chk("halt halted1", 32'(halt1), 32'd1);
        repeat (20) begin
            drive_and_check();
            chk("halt cw0_zero", 32'(cw0), 32'd0);
            chk("halt cw1_zero", 32'(cw1), 32'd0);
            advance();
        end
        #1 async_reset = 1'b0;
        #1;
        check_reset_outputs("halt_reset_pulse");
        @(negedge clk);
        async_reset = 1'b1;
        model_reset();
        drive_and_check();
        advance();

        // Reset asserted during T5 of ADD drops controls without a clock edge.
        apply_reset();
        cur_op[0] = 4'd1;
        cur_op[1] = 4'd1;
        repeat (4) begin
            drive_and_check();
            advance();
        end
        drive_and_check();
        chk("midreset T5 cw0", 32'(cw0), 32'h108);
        #1 async_reset = 1'b0;
        #1;
        check_reset_outputs("midreset_immediate");
        @(negedge clk);
        check_reset_outputs("midreset_held");
        async_reset = 1'b1;
        model_reset();
        drive_and_check();
        chk("midreset restart T1", 32'(ts0), 32'h01);
        advance();
        drive_and_check();
        advance();

        // Random opcode stream against the reference model.
        apply_reset();
        repeat (200) begin
            drive_and_check();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
